// File: rtl/mon_tx_arbiter.sv
// Round-robin arbiter that funnels three requesters' 40-bit monitor frames
// into a single Sender, with a programmable idle gap after each frame.
module mon_tx_arbiter #(
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic         mon_clk,
  input  logic         n_reset,
  input  logic [2:0]   req_valid,
  input  logic [119:0] req_data,
  output logic [2:0]   req_ack,
  output logic [39:0]  tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [1:0]   grant_id,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  localparam logic [3:0] GapInit = 4'(GAP_CYCLES);

  state_e      state_q;
  logic [3:0]  gap_cnt_q;
  logic [1:0]  last_q;

  logic [1:0]  cand1_d, cand2_d, cand3_d;
  logic [1:0]  winner_d;
  logic        found_d;
  logic [39:0] winner_data_d;

  function automatic logic [1:0] nextIdx(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Search order starts just after the previous winner so every requester gets a turn.
  always_comb begin
    cand1_d  = nextIdx(last_q);
    cand2_d  = nextIdx(cand1_d);
    cand3_d  = nextIdx(cand2_d);
    winner_d = 2'd0;
    found_d  = 1'b0;
    if (req_valid[cand1_d]) begin
      winner_d = cand1_d;
      found_d  = 1'b1;
    end else if (req_valid[cand2_d]) begin
      winner_d = cand2_d;
      found_d  = 1'b1;
    end else if (req_valid[cand3_d]) begin
      winner_d = cand3_d;
      found_d  = 1'b1;
    end
    case (winner_d)
      2'd1:    winner_data_d = req_data[79:40];
      2'd2:    winner_data_d = req_data[119:80];
      default: winner_data_d = req_data[39:0];
    endcase
  end

  always_ff @(posedge mon_clk) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      gap_cnt_q <= 4'd0;
      last_q    <= 2'd2;
      req_ack   <= 3'b000;
      tx_data   <= 40'd0;
      tx_valid  <= 1'b0;
      grant_id  <= 2'd0;
      busy      <= 1'b0;
    end else begin
      req_ack <= 3'b000;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            state_q  <= SEND;
            tx_data  <= winner_data_d;
            tx_valid <= 1'b1;
            grant_id <= winner_d;
            last_q   <= winner_d;
            req_ack  <= 3'b001 << winner_d;
            busy     <= 1'b1;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (GapInit == 4'd0) begin
              state_q <= IDLE;
              busy    <= 1'b0;
            end else begin
              state_q   <= GAP;
              gap_cnt_q <= GapInit;
            end
          end
        end
        GAP: begin
          // Leaving on the count-of-one edge yields exactly GAP_CYCLES cycles here.
          if (gap_cnt_q <= 4'd1) begin
            state_q   <= IDLE;
            gap_cnt_q <= 4'd0;
            busy      <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mon_tx_arbiter.sv
// Directed self-checking bench for mon_tx_arbiter: one DUT with the default
// gap of four cycles and a second built with no gap at all.
module tb_mon_tx_arbiter;

  logic         clk = 1'b0;
  logic         nReset;
  logic [2:0]   reqValid, reqValid0;
  logic [119:0] reqData, reqData0;
  logic         txReady, txReady0;
  logic [2:0]   reqAck, reqAck0;
  logic [39:0]  txData, txData0;
  logic         txValid, txValid0;
  logic [1:0]   grantId, grantId0;
  logic         busy, busy0;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [39:0] D0 = 40'h12_3456_789A;
  localparam logic [39:0] D1 = 40'hA5_5AA5_5A01;
  localparam logic [39:0] D2 = 40'hC3_0FF0_3C02;

  always #5 clk = ~clk;

  mon_tx_arbiter #(.GAP_CYCLES(4)) dut (
    .mon_clk(clk), .n_reset(nReset), .req_valid(reqValid), .req_data(reqData),
    .req_ack(reqAck), .tx_data(txData), .tx_valid(txValid), .tx_ready(txReady),
    .grant_id(grantId), .busy(busy)
  );

  mon_tx_arbiter #(.GAP_CYCLES(0)) dut0 (
    .mon_clk(clk), .n_reset(nReset), .req_valid(reqValid0), .req_data(reqData0),
    .req_ack(reqAck0), .tx_data(txData0), .tx_valid(txValid0), .tx_ready(txReady0),
    .grant_id(grantId0), .busy(busy0)
  );

  // Advance one clock and settle just after the edge, where outputs are sampled and inputs driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    nReset    = 1'b0;
    reqValid  = 3'b000;
    reqValid0 = 3'b000;
    reqData   = {D2, D1, D0};
    reqData0  = {D2, D1, D0};
    txReady   = 1'b1;
    txReady0  = 1'b1;
    tick();
    tick();
    nReset = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    nReset = 1'b0;
    tick();
    vectors++;
    if ({txValid, busy, reqAck, grantId} !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got valid=%b busy=%b ack=%b gid=%0d, expected all zero",
               txValid, busy, reqAck, grantId);
    end
    vectors++;
    if (txData !== 40'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got %h expected 0", txData);
    end
    nReset = 1'b1;
  endtask

  task automatic test_single();
    doReset();
    reqValid = 3'b001;
    tick();
    vectors++;
    if (reqAck !== 3'b001 || txValid !== 1'b1 || txData !== D0 || grantId !== 2'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_grant: got ack=%b valid=%b data=%h gid=%0d busy=%b, expected 001 1 %h 0 1",
               reqAck, txValid, txData, grantId, busy, D0);
    end
    reqValid = 3'b000;
    tick();
    vectors++;
    if (txValid !== 1'b0 || busy !== 1'b1 || reqAck !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL single_accept: got valid=%b busy=%b ack=%b, expected 0 1 000", txValid, busy, reqAck);
    end
    for (int g = 2; g <= 4; g++) begin
      tick();
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL single_gap%0d: got busy=%b expected 1", g, busy);
      end
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || txValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_idle: got busy=%b valid=%b expected 0 0", busy, txValid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  expId;
    logic [39:0] expData;
    int cyc, lastCyc;
    bit found;
    doReset();
    reqValid = 3'b111;
    cyc = 0;
    lastCyc = 0;
    for (int g = 0; g < 6; g++) begin
      expId = 2'(g % 3);
      expData = (expId == 2'd0) ? D0 : (expId == 2'd1) ? D1 : D2;
      found = 1'b0;
      for (int t = 0; t < 12 && !found; t++) begin
        tick();
        cyc++;
        if (reqAck !== 3'b000) found = 1'b1;
      end
      vectors++;
      if (!found) begin
        miscompares++;
        $display("[TB] FAIL rr_timeout%0d: got no ack within 12 cycles, expected ack for %0d", g, expId);
      end else begin
        vectors++;
        if (grantId !== expId || reqAck !== (3'b001 << expId) || txData !== expData) begin
          miscompares++;
          $display("[TB] FAIL rr_grant%0d: got gid=%0d ack=%b data=%h expected gid=%0d data=%h",
                   g, grantId, reqAck, txData, expId, expData);
        end
        if (g > 0) begin
          vectors++;
          if (cyc - lastCyc != 6) begin
            miscompares++;
            $display("[TB] FAIL rr_spacing%0d: got %0d cycles expected 6", g, cyc - lastCyc);
          end
        end
        lastCyc = cyc;
      end
    end
    reqValid = 3'b000;
  endtask

  task automatic test_backpressure();
    int extraAcks;
    doReset();
    reqValid = 3'b010;
    txReady  = 1'b0;
    tick();
    vectors++;
    if (reqAck !== 3'b010 || txValid !== 1'b1 || txData !== D1 || grantId !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL bp_grant: got ack=%b valid=%b data=%h gid=%0d expected 010 1 %h 1",
               reqAck, txValid, txData, grantId, D1);
    end
    reqValid = 3'b000;
    reqData  = {D2, D0, D0};
    for (int i = 1; i <= 10; i++) begin
      tick();
      vectors++;
      if (txValid !== 1'b1 || txData !== D1 || reqAck !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL bp_hold%0d: got valid=%b data=%h ack=%b expected 1 %h 000",
                 i, txValid, txData, reqAck, D1);
      end
    end
    txReady = 1'b1;
    tick();
    vectors++;
    if (txValid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_accept: got valid=%b busy=%b expected 0 1", txValid, busy);
    end
    extraAcks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (reqAck !== 3'b000 || txValid !== 1'b0) extraAcks++;
    end
    vectors++;
    if (extraAcks != 0) begin
      miscompares++;
      $display("[TB] FAIL bp_no_extra: got %0d cycles with ack/valid expected 0", extraAcks);
    end
  endtask

  task automatic test_mid_reset();
    doReset();
    reqValid = 3'b010;
    txReady  = 1'b0;
    tick();
    reqValid = 3'b000;
    nReset   = 1'b0;
    txReady  = 1'b1;
    tick();
    vectors++;
    if (txValid !== 1'b0 || busy !== 1'b0 || grantId !== 2'd0 || reqAck !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL midrst_state: got valid=%b busy=%b gid=%0d ack=%b expected 0 0 0 000",
               txValid, busy, grantId, reqAck);
    end
    nReset = 1'b1;
    tick();
    vectors++;
    if (reqAck !== 3'b000 || txValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_no_reack: got ack=%b valid=%b expected 000 0", reqAck, txValid);
    end
    reqValid = 3'b111;
    tick();
    vectors++;
    if (reqAck !== 3'b001 || grantId !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL midrst_priority: got ack=%b gid=%0d expected 001 0", reqAck, grantId);
    end
    reqValid = 3'b000;
  endtask

  task automatic test_gap_zero();
    doReset();
    reqValid0 = 3'b011;
    tick();
    vectors++;
    if (reqAck0 !== 3'b001 || txValid0 !== 1'b1 || grantId0 !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL gap0_first: got ack=%b valid=%b gid=%0d expected 001 1 0", reqAck0, txValid0, grantId0);
    end
    reqValid0 = 3'b010;
    tick();
    vectors++;
    if (txValid0 !== 1'b0 || busy0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL gap0_idle: got valid=%b busy=%b expected 0 0", txValid0, busy0);
    end
    tick();
    vectors++;
    if (txValid0 !== 1'b1 || reqAck0 !== 3'b010 || grantId0 !== 2'd1 || txData0 !== D1) begin
      miscompares++;
      $display("[TB] FAIL gap0_second: got valid=%b ack=%b gid=%0d data=%h expected 1 010 1 %h",
               txValid0, reqAck0, grantId0, txData0, D1);
    end
    reqValid0 = 3'b000;
  endtask

  task automatic test_late_arrival();
    doReset();
    reqValid = 3'b001;
    tick();
    reqValid = 3'b000;
    tick();
    reqValid = 3'b100;
    for (int g = 2; g <= 4; g++) begin
      tick();
      vectors++;
      if (reqAck !== 3'b000 || busy !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL late_gap%0d: got ack=%b busy=%b expected 000 1", g, reqAck, busy);
      end
    end
    tick();
    vectors++;
    if (reqAck !== 3'b000 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL late_idle: got ack=%b busy=%b expected 000 0", reqAck, busy);
    end
    tick();
    vectors++;
    if (reqAck !== 3'b100 || grantId !== 2'd2 || txData !== D2) begin
      miscompares++;
      $display("[TB] FAIL late_grant: got ack=%b gid=%0d data=%h expected 100 2 %h", reqAck, grantId, txData, D2);
    end
    reqValid = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    test_gap_zero();
    test_late_arrival();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
